// File: rtl/cross_mul_pkg.sv
// cross_mul_pkg
// Shared definitions for the cross-product multiplier scheduler:
//   - state_t : scheduler FSM states (IDLE, MUL1, MUL2)
//   - NREQ_DEF, W_DEF, IDW_DEF : default requester count, operand width, id width
//   - sext    : widens a 2*W_DEF-bit signed product to 2*W_DEF+1 bits
package cross_mul_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 11;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2
  } state_t;

  function automatic logic signed [2*W_DEF:0] sext(input logic signed [2*W_DEF-1:0] p);
    return {p[2*W_DEF-1], p};
  endfunction

endpackage

// File: rtl/cross_mul_sched_rr_pick.sv
// rr_pick
// Combinational round-robin scan. Starting at ptr and wrapping modulo NREQ,
// it returns the first requester whose req bit is set.
// Ports:
//   req : per-requester request level
//   ptr : index at which the scan starts
//   any : at least one request is pending
//   idx : winning requester index (0 when any is low)
module rr_pick
  import cross_mul_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  int pos;

  // Walk the offsets from farthest to nearest so the offset closest to ptr
  // is the one written last and therefore wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NREQ;
      if (req[pos]) begin
        any = 1'b1;
        idx = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/cross_mul_sched.sv
// cross_mul_sched
// Time-shares one signed multiplier among NREQ requesters. A granted request
// computes d = a1*b1 - a2*b2 over three cycles (grant, MUL1, MUL2) and
// returns d, its sign flag and the requester id. Arbitration is round-robin.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   req       : per-requester request level
//   a1,b1,a2,b2 : packed signed operands, slice i belongs to requester i
//   gnt       : one-hot grant pulse, operands captured on the same edge
//   rsp_valid : one-cycle result pulse
//   rsp_id    : requester owning the result
//   rsp_diff  : signed a1*b1 - a2*b2, full 2W+1 bits
//   rsp_gt    : rsp_diff > 0
module cross_mul_sched
  import cross_mul_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*W-1:0]     a1,
  input  logic [NREQ*W-1:0]     b1,
  input  logic [NREQ*W-1:0]     a2,
  input  logic [NREQ*W-1:0]     b2,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic signed [2*W:0]   rsp_diff,
  output logic                  rsp_gt
);

  state_t                  state;
  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          cur_id;
  logic signed [W-1:0]     cap_a1, cap_b1, cap_a2, cap_b2;
  logic signed [2*W-1:0]   p1;

  logic                    pick_any;
  logic [IDW-1:0]          pick_idx;

  logic signed [W-1:0]     mul_x, mul_y;
  logic signed [2*W-1:0]   prod;
  logic signed [2*W:0]     diff;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // The single multiplier: a1*b1 while in MUL1, a2*b2 otherwise (used in MUL2).
  assign mul_x = (state == MUL1) ? cap_a1 : cap_a2;
  assign mul_y = (state == MUL1) ? cap_b1 : cap_b2;
  assign prod  = mul_x * mul_y;

  // One extra bit makes the subtraction exact for all operand values.
  assign diff = {p1[2*W-1], p1} - {prod[2*W-1], prod};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      cap_a1    <= '0;
      cap_b1    <= '0;
      cap_a2    <= '0;
      cap_b2    <= '0;
      p1        <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_diff  <= '0;
      rsp_gt    <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt    <= NREQ'(1) << pick_idx;
            cap_a1 <= a1[int'(pick_idx)*W +: W];
            cap_b1 <= b1[int'(pick_idx)*W +: W];
            cap_a2 <= a2[int'(pick_idx)*W +: W];
            cap_b2 <= b2[int'(pick_idx)*W +: W];
            cur_id <= pick_idx;
            ptr    <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
            state  <= MUL1;
          end
        end
        MUL1: begin
          p1    <= prod;
          state <= MUL2;
        end
        MUL2: begin
          rsp_diff  <= diff;
          rsp_gt    <= !diff[2*W] && (diff != '0);
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cross_mul_sched.sv
// tb_cross_mul_sched
// Self-checking bench for cross_mul_sched. A transaction-level reference model
// tracks when the shared multiplier is free, which requester wins the
// round-robin scan, and the arithmetic result each grant must produce.
module tb_cross_mul_sched;

  localparam int NREQ = 4;
  localparam int W    = 11;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   a1, b1, a2, b2;
  logic [NREQ-1:0]     gnt;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic signed [2*W:0] rsp_diff;
  logic                rsp_gt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int              m_ptr;
  int              m_busy;
  int              m_pend_id;
  int              m_pend_diff;
  logic [NREQ-1:0] exp_gnt;
  logic            exp_valid;
  int              exp_id;
  int              exp_diff;
  logic            exp_gt;

  // grant log for the fairness scenario
  int gnt_log_id[$];
  int gnt_log_edge[$];
  int edge_count;

  cross_mul_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a1        (a1),
    .b1        (b1),
    .a2        (a2),
    .b2        (b2),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_diff  (rsp_diff),
    .rsp_gt    (rsp_gt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int opOf(input logic [NREQ*W-1:0] bus, input int i);
    logic signed [W-1:0] v;
    v = bus[i*W +: W];
    return int'(v);
  endfunction

  task automatic setOps(input int i, input int va1, input int vb1,
                        input int va2, input int vb2);
    a1[i*W +: W] = W'(va1);
    b1[i*W +: W] = W'(vb1);
    a2[i*W +: W] = W'(va2);
    b2[i*W +: W] = W'(vb2);
  endtask

  function automatic int randOp();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic modelReset();
    m_ptr     = 0;
    m_busy    = 0;
    exp_gnt   = '0;
    exp_valid = 1'b0;
    exp_id    = 0;
    exp_diff  = 0;
    exp_gt    = 1'b0;
  endtask

  // One rising edge of the model: a grant takes the multiplier for three
  // edges and the result appears after the third of them.
  task automatic modelEdge();
    bit found;
    int j;
    exp_gnt   = '0;
    exp_valid = 1'b0;
    if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (!found && req[j]) begin
          found = 1;
          exp_gnt[j]  = 1'b1;
          m_pend_id   = j;
          m_pend_diff = opOf(a1, j) * opOf(b1, j) - opOf(a2, j) * opOf(b2, j);
          m_ptr       = (j + 1) % NREQ;
          m_busy      = 2;
        end
      end
    end else begin
      m_busy--;
      if (m_busy == 0) begin
        exp_valid = 1'b1;
        exp_id    = m_pend_id;
        exp_diff  = m_pend_diff;
        exp_gt    = (m_pend_diff > 0);
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("gnt", gnt, exp_gnt);
    checkOutput("gnt_onehot", ($countones(gnt) <= 1), 1);
    checkOutput("rsp_valid", rsp_valid, exp_valid);
    checkOutput("rsp_id", rsp_id, exp_id);
    checkOutput("rsp_diff", rsp_diff, exp_diff);
    checkOutput("rsp_gt", rsp_gt, exp_gt);
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        gnt_log_id.push_back(i);
        gnt_log_edge.push_back(edge_count);
      end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
    edge_count++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    req = r;
    stepCycle();
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Issue one operation on an idle block and check the result against a
  // hand-computed constant. Optionally scribble over the operands after grant.
  task automatic runOp(input int i, input int va1, input int vb1, input int va2,
                       input int vb2, input int want, input bit scribble);
    setOps(i, va1, vb1, va2, vb2);
    applyStimulus(NREQ'(1) << i);
    checkOutput("dir_gnt", gnt, NREQ'(1) << i);
    if (scribble) setOps(i, -1, -1, -1, -1);
    applyStimulus('0);
    applyStimulus('0);
    checkOutput("dir_valid", rsp_valid, 1);
    checkOutput("dir_id", rsp_id, i);
    checkOutput("dir_diff", rsp_diff, want);
    checkOutput("dir_gt", rsp_gt, want > 0);
    applyStimulus('0);
  endtask

  initial begin
    req        = '0;
    a1         = '0;
    b1         = '0;
    a2         = '0;
    b2         = '0;
    edge_count = 0;
    m_pend_id  = 0;
    m_pend_diff = 0;
    doReset();

    // single requester
    runOp(2, 3, 4, 2, 5, 2, 1'b0);

    // fairness from reset with all requesters asserted
    doReset();
    for (int i = 0; i < NREQ; i++) setOps(i, i + 1, 2, 1, i);
    gnt_log_id.delete();
    gnt_log_edge.delete();
    edge_count = 0;
    for (int c = 0; c < 13; c++) applyStimulus(4'b1111);
    checkOutput("fair_count", gnt_log_id.size(), 5);
    if (gnt_log_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        checkOutput("fair_id", gnt_log_id[k], k % NREQ);
        checkOutput("fair_edge", gnt_log_edge[k], 3 * k);
      end
    end
    applyStimulus('0);
    applyStimulus('0);
    applyStimulus('0);

    // negative, zero and boundary results
    runOp(1, -5, 7, 5, -7, 0, 1'b0);
    runOp(1, -1024, 1023, 0, 500, -1047552, 1'b0);
    runOp(3, -1024, -1024, 0, 0, 1048576, 1'b0);
    runOp(0, 0, 0, -1024, 1023, 1047552, 1'b0);
    runOp(2, -1024, -1024, -1024, 1023, 2096128, 1'b0);

    // operand hazard: operands overwritten after capture
    runOp(0, 100, -37, -12, 55, -3040, 1'b1);

    // reset glitch in MUL1 after a grant that moved ptr away from 0
    doReset();
    setOps(2, 9, 9, 1, 1);
    applyStimulus(4'b0100);
    req = '0;
    #1 reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus('0);
    setOps(1, 6, 6, 2, 3);
    setOps(3, 1, 1, 1, 1);
    applyStimulus(4'b1010);
    checkOutput("rr_after_reset", gnt, 4'b0010);
    for (int c = 0; c < 3; c++) applyStimulus('0);

    // randomized requesters following the handshake
    for (int i = 0; i < NREQ; i++) setOps(i, randOp(), randOp(), randOp(), randOp());
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          setOps(i, randOp(), randOp(), randOp(), randOp());
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          setOps(i, randOp(), randOp(), randOp(), randOp());
        end
      end
      stepCycle();
    end
    req = '0;
    for (int c = 0; c < 4; c++) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
